// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and shared-memory bus signals of mem_port_arbiter
// Port summary (directions as seen by the arbiter, i.e. the slave modport):
//   imem_req_i/imem_addr_i                           fetch request in
//   imem_rdata_o/imem_ack_o/imem_err_o               fetch response out
//   dmem_req_i/dmem_we_i/dmem_addr_i/dmem_wdata_i    data request in
//   dmem_rdata_o/dmem_ack_o/dmem_err_o               data response out
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o        shared-memory request out
//   mem_rdata_i/mem_ack_i                            shared-memory response in
// The master modport is the surrounding system: processor ports plus memory.
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req_i;
  logic [ADDR_WIDTH-1:0] imem_addr_i;
  logic [DATA_WIDTH-1:0] imem_rdata_o;
  logic                  imem_ack_o;
  logic                  imem_err_o;
  logic                  dmem_req_i;
  logic                  dmem_we_i;
  logic [ADDR_WIDTH-1:0] dmem_addr_i;
  logic [DATA_WIDTH-1:0] dmem_wdata_i;
  logic [DATA_WIDTH-1:0] dmem_rdata_o;
  logic                  dmem_ack_o;
  logic                  dmem_err_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_ack_i;

  modport slave (
    input  imem_req_i, imem_addr_i,
    input  dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
    input  mem_rdata_i, mem_ack_i,
    output imem_rdata_o, imem_ack_o, imem_err_o,
    output dmem_rdata_o, dmem_ack_o, dmem_err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output imem_req_i, imem_addr_i,
    output dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
    output mem_rdata_i, mem_ack_i,
    input  imem_rdata_o, imem_ack_o, imem_err_o,
    input  dmem_rdata_o, dmem_ack_o, dmem_err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and data ports
// Ports:
//   clk_i  single clock
//   rst_i  synchronous active-high reset; aborts any access in flight without an ack
//   bus    mem_port_arbiter_if.slave: fetch/data request+response ports and the
//          registered shared-memory request with its rdata/ack return
// Build option: MEM_ARB_RR_EN selects round-robin between simultaneous requests;
// without it data always beats fetch.
// Access flow: IDLE (arbitrate, register request) -> BUSY (wait ack or timeout)
// -> RESP (one-cycle ack to the owner) -> IDLE.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IMEM, OWN_DMEM} owner_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] imem_rdata_q, imem_rdata_d;
  logic                  imem_ack_q, imem_ack_d;
  logic                  imem_err_q, imem_err_d;
  logic [DATA_WIDTH-1:0] dmem_rdata_q, dmem_rdata_d;
  logic                  dmem_ack_q, dmem_ack_d;
  logic                  dmem_err_q, dmem_err_d;
  logic                  grant_dmem;

`ifdef MEM_ARB_RR_EN
  // 1 = the data port won the most recent grant; reset value points at fetch
  logic rr_last_dmem_q, rr_last_dmem_d;
  // On contention the port that did not win last time gets the grant.
  assign grant_dmem = bus.dmem_req_i & (~bus.imem_req_i | ~rr_last_dmem_q);
`else
  assign grant_dmem = bus.dmem_req_i;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    imem_rdata_d = imem_rdata_q;
    imem_err_d   = imem_err_q;
    dmem_rdata_d = dmem_rdata_q;
    dmem_err_d   = dmem_err_q;
    imem_ack_d   = 1'b0;
    dmem_ack_d   = 1'b0;
`ifdef MEM_ARB_RR_EN
    rr_last_dmem_d = rr_last_dmem_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.imem_req_i || bus.dmem_req_i) begin
          state_d   = ST_BUSY;
          mem_req_d = 1'b1;
          cnt_d     = 8'd0;
          if (grant_dmem) begin
            owner_d     = OWN_DMEM;
            mem_we_d    = bus.dmem_we_i;
            mem_addr_d  = bus.dmem_addr_i;
            mem_wdata_d = bus.dmem_wdata_i;
          end else begin
            owner_d     = OWN_IMEM;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.imem_addr_i;
            mem_wdata_d = '0;
          end
`ifdef MEM_ARB_RR_EN
          rr_last_dmem_d = grant_dmem;
`endif
        end
      end
      ST_BUSY: begin
        // Ack is tested first so it wins over a timeout firing in the same cycle.
        if (bus.mem_ack_i || cnt_q == CNT_LAST) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          if (owner_q == OWN_DMEM) begin
            dmem_ack_d   = 1'b1;
            dmem_rdata_d = bus.mem_ack_i ? bus.mem_rdata_i : '0;
            dmem_err_d   = ~bus.mem_ack_i;
          end else begin
            imem_ack_d   = 1'b1;
            imem_rdata_d = bus.mem_ack_i ? bus.mem_rdata_i : '0;
            imem_err_d   = ~bus.mem_ack_i;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        // The ack flop is high during this state; it drops on the way back to IDLE.
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      cnt_q        <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      imem_rdata_q <= '0;
      imem_ack_q   <= 1'b0;
      imem_err_q   <= 1'b0;
      dmem_rdata_q <= '0;
      dmem_ack_q   <= 1'b0;
      dmem_err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_last_dmem_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      imem_rdata_q <= imem_rdata_d;
      imem_ack_q   <= imem_ack_d;
      imem_err_q   <= imem_err_d;
      dmem_rdata_q <= dmem_rdata_d;
      dmem_ack_q   <= dmem_ack_d;
      dmem_err_q   <= dmem_err_d;
`ifdef MEM_ARB_RR_EN
      rr_last_dmem_q <= rr_last_dmem_d;
`endif
    end
  end

  assign bus.mem_req_o    = mem_req_q;
  assign bus.mem_we_o     = mem_we_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_wdata_o  = mem_wdata_q;
  assign bus.imem_rdata_o = imem_rdata_q;
  assign bus.imem_ack_o   = imem_ack_q;
  assign bus.imem_err_o   = imem_err_q;
  assign bus.dmem_rdata_o = dmem_rdata_q;
  assign bus.dmem_ack_o   = dmem_ack_q;
  assign bus.dmem_err_o   = dmem_err_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port memory between the processor's instruction-fetch port and data port.
- Arbitrates between the two requests and registers the winning request onto the shared memory bus.
- Captures the read data and returns a one-cycle ack, with an error flag, to the winning requester.
- Sits between simple_processor and the unified memory, replacing separate IMEM/DMEM connections.
- Includes a watchdog that terminates any memory access not acked within a bounded number of cycles.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
TIMEOUT_CYCLES, 16, max cycles mem_req_o stays high without mem_ack_i before the access is aborted (legal range 1..255)

Ports:
clk_i  input  1  global clock; single clock domain
rst_i  input  1  synchronous, active-high reset
imem_req_i  input  1  fetch request; held with imem_addr_i stable until imem_ack_o
imem_addr_i  input  ADDR_WIDTH  fetch address
imem_rdata_o  output  DATA_WIDTH  fetch read data; valid when imem_ack_o=1
imem_ack_o  output  1  one-cycle fetch completion pulse
imem_err_o  output  1  fetch timed out; valid when imem_ack_o=1
dmem_req_i  input  1  data request; held with addr/we/wdata stable until dmem_ack_o
dmem_we_i  input  1  1=write, 0=read
dmem_addr_i  input  ADDR_WIDTH  data address
dmem_wdata_i  input  DATA_WIDTH  write data
dmem_rdata_o  output  DATA_WIDTH  data read data; valid when dmem_ack_o=1
dmem_ack_o  output  1  one-cycle data completion pulse
dmem_err_o  output  1  data access timed out; valid when dmem_ack_o=1
mem_req_o  output  1  shared-memory request, registered
mem_we_o  output  1  shared-memory write enable, registered
mem_addr_o  output  ADDR_WIDTH  shared-memory address, registered
mem_wdata_o  output  DATA_WIDTH  shared-memory write data, registered
mem_rdata_i  input  DATA_WIDTH  shared-memory read data; sampled when mem_ack_i=1
mem_ack_i  input  1  shared-memory completion

Behaviour:
- Reset: rst_i is synchronous and active-high and is sampled on the rising edge of clk_i.
- Values after reset: all outputs 0, state=IDLE, timeout counter=0, owner=NONE, round-robin pointer=IMEM.
- Reset during an access aborts it immediately. No ack is issued, and mem_req_o drops in the cycle after reset is sampled.
- Memory side: mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are flops.
  - mem_we_o, mem_addr_o and mem_wdata_o hold their value throughout BUSY.
  - mem_we_o is forced to 0 for IMEM grants.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any request is asserted, select a winner per the arbitration rule.
  - Register the winner's addr/we/wdata, set mem_req_o=1, clear the counter, and go to BUSY.
  - If no request is asserted, stay in IDLE.
- BUSY, on mem_ack_i=1:
  - Latch mem_rdata_i into the winner's rdata register, clear err, drop mem_req_o, and go to RESP.
  - Write accesses also latch mem_rdata_i; the value is don't-care for the requester.
- BUSY, on mem_ack_i=0:
  - Increment the counter.
  - When counter==TIMEOUT_CYCLES-1 and mem_ack_i=0, drop mem_req_o, set rdata=0 and err=1, and go to RESP.
- BUSY, mem_ack_i arriving in the same cycle the timeout fires: the ack wins and the access completes normally with err=0.
- RESP:
  - Pulse the owner's ack_o for exactly one cycle with rdata_o and err_o valid, then go to IDLE.
  - The non-owner's ack stays 0.
- Arbitration is performed only in IDLE, so the back-to-back issue rate is one new access per 3 cycles minimum.
- Latency, zero-wait memory (mem_ack_i asserted in the first BUSY cycle): request sampled at cycle 0 → mem_req_o high in cycle 1 → ack_o in cycle 2.
- Default arbitration is fixed priority: dmem beats imem.
- A requester that drops req while its access is in BUSY does not cancel the access; the ack is still issued.
- A requester still holding req in the cycle after its ack is treated as a new request.
- rdata_o and err_o retain their last value between acks.
- mem_ack_i asserted while in IDLE or RESP is ignored.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both requests are asserted in IDLE, grant the port not granted last; the pointer updates on every grant.
  - A single requester is always granted immediately.
- Undefined: fixed dmem>imem priority and no pointer flop.
  - imem can starve while dmem requests continuously.

Test Plan:
- Reset: assert rst_i for 2 cycles with both reqs high → all outputs 0; the first grant occurs 1 cycle after rst_i falls.
- Zero-wait read: imem_req_i=1, imem_addr_i=0x100, memory acks in the first BUSY cycle with 0xDEADBEEF → mem_addr_o=0x100 and mem_we_o=0 in cycle 1; imem_ack_o=1, imem_rdata_o=0xDEADBEEF, imem_err_o=0 in cycle 2.
- Write with 3-cycle memory wait: dmem_we_i=1, dmem_addr_i=0x20, dmem_wdata_i=0x1234 → mem_req_o high for 4 cycles with fields stable; dmem_ack_o pulses once; imem_ack_o stays 0.
- Contention: both reqs held for 4 consecutive grants.
  - Default build: 4 dmem grants.
  - MEM_ARB_RR_EN build: grant order D, I, D, I.
- Timeout: dmem read, memory never acks → mem_req_o drops after 16 cycles; dmem_ack_o=1, dmem_err_o=1, dmem_rdata_o=0.
  - Repeat with mem_ack_i arriving on cycle 16 → err=0 and data is returned.
- Mid-access reset: assert rst_i in the 2nd BUSY cycle → mem_req_o=0 next cycle; no ack is issued; the FSM returns to IDLE.
